// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse MixColumns datapath: GF(2^8) helpers,
// the inverse coefficient row, column geometry and the engine FSM encoding.
package aes_pkg;

  localparam int unsigned ColWidth = 32;
  localparam int unsigned ColCount = 4;
  localparam int unsigned StateWidth = ColWidth * ColCount;

  // Row 0 coefficients {0e,0b,0d,09}; each lower row uses this row rotated right once more.
  localparam logic [7:0]  InvCoef0    = 8'h0e;
  localparam logic [7:0]  InvCoef1    = 8'h0b;
  localparam logic [7:0]  InvCoef2    = 8'h0d;
  localparam logic [7:0]  InvCoef3    = 8'h09;
  localparam logic [31:0] InvCoeffRow = {InvCoef0, InvCoef1, InvCoef2, InvCoef3};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } inv_mix_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Coefficient is always a constant at the call sites, so this folds to one multiplier.
  function automatic logic [7:0] mul_inv_coef(input logic [7:0] coef, input logic [7:0] b);
    logic [7:0] res;
    case (coef)
      InvCoef0: res = mul0e(b);
      InvCoef1: res = mul0b(b);
      InvCoef2: res = mul0d(b);
      default:  res = mul09(b);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column (row 0 in the MSB byte).
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [ColWidth-1:0] col_i,
  output logic [ColWidth-1:0] col_o
);

  logic [7:0] row_in [4];
  logic [7:0] acc;

  // Split the column into its four row bytes.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = col_i[31-8*r -: 8];
    end
  end

  // Output row r uses the coefficient row rotated right by r positions.
  always_comb begin
    col_o = '0;
    acc   = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int i = 0; i < 4; i++) begin
        acc = acc ^ mul_inv_coef(InvCoeffRow[31-8*((i-r+4)%4) -: 8], row_in[i]);
      end
      col_o[31-8*r -: 8] = acc;
    end
  end

endmodule

// File: rtl/inv_mixcolumn_iter.sv
// Iterative AES InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then holds the result until taken.
module inv_mixcolumn_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [StateWidth-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [StateWidth-1:0] data_out,
  output logic                  busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cfg
    $error("inv_mixcolumn_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // A step of 4 truncates to 0, which is exactly the 2-bit wrap wanted.
  localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCnt = 2'(ColCount - COLS_PER_CYCLE);

  inv_mix_state_e        state_q;
  logic [1:0]            col_cnt_q;
  logic [StateWidth-1:0] data_q;
  logic                  out_valid_q;
  logic                  busy_q;

  logic [1:0]            col_idx [COLS_PER_CYCLE];
  logic [ColWidth-1:0]   col_in  [COLS_PER_CYCLE];
  logic [ColWidth-1:0]   col_out [COLS_PER_CYCLE];
  logic [StateWidth-1:0] data_step;
  logic                  accept;

  // Ready is masked by rst so a same-cycle request can never be captured.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign busy      = busy_q;

  // Column k lives at bits [127-32k -: 32]; {~idx, 5'b0} is 32*(3-idx).
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : gen_col
    assign col_idx[j] = col_cnt_q + 2'(j);
    assign col_in[j]  = data_q[{~col_idx[j], 5'b0} +: ColWidth];

    inv_mix_single_column u_col (
      .col_i (col_in[j]),
      .col_o (col_out[j])
    );
  end

  // Next state register value in BUSY: overwrite the columns handled this cycle.
  always_comb begin
    data_step = data_q;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      data_step[{~col_idx[j], 5'b0} +: ColWidth] = col_out[j];
    end
  end

  // Engine FSM with registered out_valid/busy and the in-place state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      col_cnt_q   <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            data_q    <= data_in;
            col_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          data_q    <= data_step;
          col_cnt_q <= col_cnt_q + ColStep;
          if (col_cnt_q == LastCnt) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumn_iter.sv
// Bench: three engines (1, 2 and 4 columns per cycle) checked against a
// GF(2^8) matrix model of forward and inverse MixColumns.
module tb_inv_mixcolumn_iter;

  localparam int NumDut = 3;
  localparam logic [31:0]  FwdRow = 32'h02030101;
  localparam logic [31:0]  InvRow = 32'h0e0b0d09;
  localparam logic [127:0] V1 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] E1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V2 = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] E2 = 128'hdb135345f20a225c01010101c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [NumDut];
  logic         in_ready  [NumDut];
  logic         out_valid [NumDut];
  logic         out_ready [NumDut];
  logic         busy      [NumDut];
  logic [127:0] data_in   [NumDut];
  logic [127:0] data_out  [NumDut];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NumDut; g++) begin : gen_dut
    inv_mixcolumn_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .data_in   (data_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  // Shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product per column; row o uses the coefficient row rotated right by o.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [31:0] row);
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int o = 0; o < 4; o++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
          acc = acc ^ gmul(row[31-8*((i-o+4)%4) -: 8], s[127-32*c-8*i -: 8]);
        end
        r[127-32*c-8*o -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one state and hold it until the accept edge, then scramble data_in.
  task automatic send(input int k, input logic [127:0] din);
    int t = 0;
    while (!in_ready[k] && t < 50) begin
      tick();
      t++;
    end
    check("send_ready", 128'(in_ready[k]), 128'd1);
    data_in[k]  = din;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    data_in[k]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  initial begin
    int lat;
    int prev_acc;
    bit seen_bad;
    logic [127:0] x;
    logic [127:0] y;

    rst = 1'b1;
    for (int k = 0; k < NumDut; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      data_in[k]   = '0;
    end
    tick();
    tick();
    for (int k = 0; k < NumDut; k++) begin
      check("rst_out_valid", 128'(out_valid[k]), 128'd0);
      check("rst_busy", 128'(busy[k]), 128'd0);
      check("rst_data_out", data_out[k], 128'd0);
      check("rst_in_ready", 128'(in_ready[k]), 128'd0);
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < NumDut; k++) check("post_rst_in_ready", 128'(in_ready[k]), 128'd1);

    // Known vectors with latency checks.
    send(0, V1);
    wait_done(0, lat);
    check("t1_latency", 128'(lat), 128'd4);
    check("t1_data", data_out[0], E1);
    check("t1_busy_done", 128'(busy[0]), 128'd1);
    drain(0);
    check("t1_in_ready", 128'(in_ready[0]), 128'd1);
    check("t1_out_valid_clr", 128'(out_valid[0]), 128'd0);

    send(0, V2);
    wait_done(0, lat);
    check("t2_data", data_out[0], E2);
    drain(0);
    send(0, 128'd0);
    wait_done(0, lat);
    check("t2_zero", data_out[0], 128'd0);
    drain(0);
    send(1, V2);
    wait_done(1, lat);
    check("t2_latency_c2", 128'(lat), 128'd2);
    check("t2_data_c2", data_out[1], E2);
    drain(1);

    // Backpressure with a competing request.
    send(0, V1);
    wait_done(0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      data_in[0]  = V2;
      tick();
      check("t3_out_valid", 128'(out_valid[0]), 128'd1);
      check("t3_data_hold", data_out[0], E1);
      check("t3_in_ready", 128'(in_ready[0]), 128'd0);
    end
    in_valid[0] = 1'b0;
    drain(0);
    check("t3_idle_ready", 128'(in_ready[0]), 128'd1);
    check("t3_no_capture", data_out[0], E1);
    tick();
    check("t3_not_busy", 128'(busy[0]), 128'd0);

    // Abort in the second BUSY cycle.
    send(0, V1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_valid", 128'(out_valid[0]), 128'd0);
    check("t4_data_out", data_out[0], 128'd0);
    check("t4_busy", 128'(busy[0]), 128'd0);
    seen_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0]) seen_bad = 1'b1;
    end
    check("t4_no_partial", 128'(seen_bad), 128'd0);
    send(0, V1);
    wait_done(0, lat);
    check("t4_latency", 128'(lat), 128'd4);
    check("t4_data", data_out[0], E1);
    drain(0);

    // Reset wins over a simultaneous request.
    rst         = 1'b1;
    in_valid[1] = 1'b1;
    data_in[1]  = V1;
    tick();
    rst         = 1'b0;
    in_valid[1] = 1'b0;
    tick();
    check("t4_rst_wins_busy", 128'(busy[1]), 128'd0);
    check("t4_rst_wins_data", data_out[1], 128'd0);

    // Back-to-back with four columns per cycle.
    out_ready[2] = 1'b1;
    prev_acc     = 0;
    for (int b = 0; b < 4; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(2, x);
      if (b > 0) check("t5_interval", 128'(cyc - prev_acc), 128'd3);
      prev_acc = cyc;
      wait_done(2, lat);
      check("t5_latency", 128'(lat), 128'd1);
      check("t5_data", data_out[2], mix(x, InvRow));
      tick();
    end
    out_ready[2] = 1'b0;

    // Round trip through the forward transform for every width.
    for (int k = 0; k < NumDut; k++) begin
      for (int n = 0; n < 100; n++) begin
        x = {$urandom, $urandom, $urandom, $urandom};
        y = mix(x, FwdRow);
        send(k, y);
        wait_done(k, lat);
        check("t6_latency", 128'(lat), 128'(4 >> k));
        check("t6_roundtrip", data_out[k], x);
        repeat ($urandom_range(0, 2)) tick();
        drain(k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inv_mixcolumn_iter.md
Name: inv_mixcolumn_iter

Overview:
- Iterative AES InvMixColumns engine for the decryption datapath; it is the inverse of the existing forward mixcolumn block.
- Accepts one 128-bit state over a valid/ready handshake and applies the inverse column transform.
- Processes COLS_PER_CYCLE 32-bit columns per clock, then holds the result until the downstream stage accepts it.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round loop.

Parameters:
- COLS_PER_CYCLE, 1, number of columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  data_in holds a state to transform
- in_ready  out  1  block can accept a state
- data_in  in  128  input state
- out_valid  out  1  data_out holds a completed result
- out_ready  in  1  downstream accepts data_out
- data_out  out  128  transformed state
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst.
- Byte order (FIPS-197):
  - data_in[127:96] is column 0, data_in[31:0] is column 3.
  - Within a column, the MSB byte is row 0.
- Per column, with rows r0..r3 and GF(2^8) modulo x^8+x^4+x^3+x+1:
  - out0 = 0e·r0 ^ 0b·r1 ^ 0d·r2 ^ 09·r3
  - Rows 1..3 use the same coefficients rotated right one position per row.
- Reset, while rst is high:
  - state = IDLE, col_cnt = 0, data_out = 0, out_valid = 0, busy = 0.
  - in_ready = 0 during rst and 1 in the first cycle after release.
- FSM state IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: latch data_in into the state register, col_cnt = 0, go to BUSY.
- FSM state BUSY:
  - in_ready = 0.
  - Each edge overwrites columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 with their transformed values, then col_cnt += COLS_PER_CYCLE.
  - When the last column has been written, go to DONE.
  - BUSY lasts 4/COLS_PER_CYCLE cycles.
- FSM state DONE:
  - out_valid = 1, in_ready = 0.
  - data_out equals the state register and is stable.
  - On out_valid & out_ready at an edge: go to IDLE and clear out_valid.
- Latency: if the accept edge is N, out_valid is first high after edge N + 4/COLS_PER_CYCLE.
- Minimum block interval with out_ready tied high is 4/COLS_PER_CYCLE + 2 cycles.
- Boundary conditions:
  - in_valid while not IDLE is ignored and nothing is captured.
  - data_in may change freely after the accept edge.
  - out_ready while not DONE has no effect.
  - Backpressure: DONE is held indefinitely and data_out must not change.
  - rst during BUSY or DONE aborts the block: next cycle is IDLE, out_valid = 0, data_out = 0, and no partial result is ever flagged valid.
  - rst and in_valid in the same cycle: reset wins and nothing is captured.
  - col_cnt is 2 bits and wraps to 0 on the transition to DONE.
- data_out is registered; there is no combinational path from data_in to data_out.

Decomposition:
- Package aes_pkg holds:
  - GF multiply functions xtime, mul09, mul0b, mul0d, mul0e.
  - Constants for the inverse coefficient row {0e,0b,0d,09}.
  - FSM state encoding IDLE/BUSY/DONE.
  - Column width (32) and column count (4) constants.
- One combinational sub-module: inv_mix_single_column, 32 bits in and 32 bits out.
  - It is instantiated COLS_PER_CYCLE times.
  - Its column select is muxed by col_cnt.

Test Plan:
1. Reset, then accept 046681e5e0cb199a48f8d37a2806264c with COLS_PER_CYCLE=1 -> data_out = d4bf5d30e0b452aeb84111f11e2798e5, out_valid rising exactly 4 cycles after the accept edge.
2. Input 8e4da1bc9fdc589d01010101c6c6c6c6 -> db135345f20a225c01010101c6c6c6c6; all-zero input -> all-zero output.
3. Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with a new state -> out_valid stays 1, data_out is unchanged, in_ready stays 0, and the new state is not captured. Then raise out_ready -> the block is in IDLE with in_ready=1 on the next cycle.
4. Assert rst for one cycle in the 2nd BUSY cycle -> out_valid=0 and data_out=0. After release, a fresh block from test 1 still gives the correct result.
5. COLS_PER_CYCLE=4 with back-to-back blocks and out_ready high -> latency of 1 cycle, a 3-cycle block interval, and correct results.
6. Round trip: 100 random states through the forward mixcolumn then inv_mixcolumn_iter -> output equals the original input for all three parameter values.
